garo_move_unit: RTL and testbench



---
 rtl/garo_move_unit.sv | 110 +++++++++++
 tb/tb_garo_move_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/garo_move_unit.sv
// -----------------------------------------------------------------------------
// garo_move_unit
//
// Battle-datapath helper. Six pseudo-random bit generators (GARO cells,
// modelled as 16-bit Galois LFSRs so simulation is deterministic) feed the AI
// move index and the accuracy roll. A trainer mux picks the player's or the
// AI's move into a register, and a small move table turns that registered
// selection into damage and accuracy figures for the HP-update logic.
//
// Parameters
//   SEED  base seed; generator i starts at SEED + i*16'h1357 (mod 2^16),
//         with a zero result replaced by 16'h0001
//   TAPS  Galois feedback mask (x^16+x^14+x^13+x^11+1 by default)
//
// Ports
//   clk       in   1  clock, all state on rising edge
//   rst       in   1  synchronous reset, active-low
//   stop      in   1  1 = freeze all generators (hold state)
//   actr      in   1  active trainer: 0 = player, 1 = AI
//   p_move    in   2  player move index
//   ai_move   out  2  AI move index {gen1,gen0}
//   acc_roll  out  4  accuracy roll {gen5,gen4,gen3,gen2}
//   move_sel  out  2  registered selected move
//   dmg       out  4  damage of move_sel
//   accu      out  4  accuracy threshold of move_sel
//   hit       out  1  1 = move connects
//
// Build option
//   ACCU_CHECK_EN  when defined, hit = (accu >= acc_roll) (unsigned 4-bit);
//                  otherwise hit is tied to 1 and acc_roll is still produced.
// -----------------------------------------------------------------------------
module garo_move_unit #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stop,
  input  logic       actr,
  input  logic [1:0] p_move,
  output logic [1:0] ai_move,
  output logic [3:0] acc_roll,
  output logic [1:0] move_sel,
  output logic [3:0] dmg,
  output logic [3:0] accu,
  output logic       hit
);

  localparam int NUM_GEN = 6;

  // Seed of generator i; a zero seed would lock the LFSR at zero forever.
  function automatic logic [15:0] seed_of(input int idx);
    logic [15:0] v;
    v = SEED + (16'(idx) * 16'h1357);
    if (v == 16'h0000) v = 16'h0001;
    return v;
  endfunction

  logic [NUM_GEN-1:0] gen_bit;

  for (genvar g = 0; g < NUM_GEN; g++) begin : g_gen
    localparam logic [15:0] SEED_G = seed_of(g);
    logic [15:0] s;

    // Right-shifting Galois form: the bit shifted out folds the tap mask back in.
    always_ff @(posedge clk) begin
      if (!rst) begin
        s <= SEED_G;
      end else if (!stop) begin
        s <= {1'b0, s[15:1]} ^ (s[0] ? TAPS : 16'h0000);
      end
    end

    assign gen_bit[g] = s[0];
  end

  assign ai_move  = gen_bit[1:0];
  assign acc_roll = gen_bit[5:2];

  // Trainer mux samples ai_move before this edge's LFSR step, so the AI
  // choice lands one cycle later. It keeps updating while generators are
  // frozen.
  always_ff @(posedge clk) begin
    if (!rst) begin
      move_sel <= 2'b00;
    end else begin
      move_sel <= actr ? ai_move : p_move;
    end
  end

  // Move table, purely combinational from move_sel.
  always_comb begin
    dmg  = 4'd4;
    accu = 4'd15;
    case (move_sel)
      2'd0: begin dmg = 4'd4; accu = 4'd15; end
      2'd1: begin dmg = 4'd6; accu = 4'd12; end
      2'd2: begin dmg = 4'd8; accu = 4'd8;  end
      2'd3: begin dmg = 4'd3; accu = 4'd15; end
      default: begin dmg = 4'd4; accu = 4'd15; end
    endcase
  end

`ifdef ACCU_CHECK_EN
  assign hit = (accu >= acc_roll);
`else
  assign hit = 1'b1;
`endif

endmodule

// File: tb/tb_garo_move_unit.sv
// -----------------------------------------------------------------------------
// tb_garo_move_unit
//
// Self-checking bench for garo_move_unit: reset values, directed move-table
// vectors, stop/resume, reset mid-operation, the accuracy compare boundary,
// a randomized run against a reference model, and a full LFSR period.
// -----------------------------------------------------------------------------
module tb_garo_move_unit;

  localparam logic [15:0] TAPS = 16'hB400;

  // ---------------- clock / reset block ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       stop;
  logic       actr;
  logic [1:0] p_move;
  logic [1:0] ai_move;
  logic [3:0] acc_roll;
  logic [1:0] move_sel;
  logic [3:0] dmg;
  logic [3:0] accu;
  logic       hit;

  always #5 clk = ~clk;

  garo_move_unit dut (
    .clk      (clk),
    .rst      (rst),
    .stop     (stop),
    .actr     (actr),
    .p_move   (p_move),
    .ai_move  (ai_move),
    .acc_roll (acc_roll),
    .move_sel (move_sel),
    .dmg      (dmg),
    .accu     (accu),
    .hit      (hit)
  );

  // ---------------- reference model ----------------
  // Seeds written out from the documented reset list.
  logic [15:0] seed_tab [6];
  logic [15:0] m_s [6];
  logic [1:0]  m_sel;
  int          dmg_tab  [4];
  int          accu_tab [4];

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] exp_q [$];

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 16'h0000);
  endfunction

  function automatic logic [1:0] m_ai();
    return {m_s[1][0], m_s[0][0]};
  endfunction

  function automatic logic [3:0] m_roll();
    return {m_s[5][0], m_s[4][0], m_s[3][0], m_s[2][0]};
  endfunction

  function automatic logic m_hit(input logic [1:0] sel);
`ifdef ACCU_CHECK_EN
    return accu_tab[sel] >= int'(m_roll());
`else
    return 1'b1;
`endif
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [1:0] e_sel;
    e_sel = exp_q.pop_front();
    chk({tag, ".move_sel"}, int'(move_sel), int'(e_sel));
    chk({tag, ".ai_move"},  int'(ai_move),  int'(m_ai()));
    chk({tag, ".acc_roll"}, int'(acc_roll), int'(m_roll()));
    chk({tag, ".dmg"},      int'(dmg),      dmg_tab[e_sel]);
    chk({tag, ".accu"},     int'(accu),     accu_tab[e_sel]);
    chk({tag, ".hit"},      int'(hit),      int'(m_hit(e_sel)));
  endtask

  // ---------------- driver tasks ----------------
  // Advance model with pre-edge inputs, clock the DUT, sample 1 ns later.
  task automatic step();
    if (!rst) begin
      m_sel = 2'd0;
      for (int i = 0; i < 6; i++) m_s[i] = seed_tab[i];
    end else begin
      m_sel = actr ? m_ai() : p_move;
      if (!stop) for (int i = 0; i < 6; i++) m_s[i] = lfsr_next(m_s[i]);
    end
    exp_q.push_back(m_sel);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic a, input logic [1:0] p);
    rst = r; stop = s; actr = a; p_move = p;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       actr;
    logic [1:0] p_move;
    logic [1:0] exp_sel;
    logic [3:0] exp_dmg;
    logic [3:0] exp_accu;
  } vec_t;

  vec_t vecs [6];

  initial begin
    seed_tab = '{16'hACE1, 16'hC038, 16'hD38F, 16'hE6E6, 16'hFA3D, 16'h0D94};
    dmg_tab  = '{4, 6, 8, 3};
    accu_tab = '{15, 12, 8, 15};
    // Applied with generators frozen straight after reset, so ai_move is 1.
    vecs[0] = '{1'b0, 2'd0, 2'd0, 4'd4, 4'd15};
    vecs[1] = '{1'b0, 2'd1, 2'd1, 4'd6, 4'd12};
    vecs[2] = '{1'b0, 2'd2, 2'd2, 4'd8, 4'd8};
    vecs[3] = '{1'b0, 2'd3, 2'd3, 4'd3, 4'd15};
    vecs[4] = '{1'b1, 2'd2, 2'd1, 4'd6, 4'd12};
    vecs[5] = '{1'b1, 2'd0, 2'd1, 4'd6, 4'd12};

    drive(1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 6; i++) m_s[i] = seed_tab[i];
    m_sel = 2'd0;
    #2;

    // Reset held two cycles.
    step(); void'(exp_q.pop_front());
    step(); check_all("reset");
    chk("reset.ai_move_const",  int'(ai_move),  1);
    chk("reset.acc_roll_const", int'(acc_roll), 5);
    chk("reset.dmg_const",      int'(dmg),      4);
    chk("reset.accu_const",     int'(accu),     15);

    // First edge after release with actr=1 picks the AI move (1).
    drive(1'b1, 1'b0, 1'b1, 2'd3);
    step(); check_all("ai_first");
    chk("ai_first.move_sel", int'(move_sel), 1);
    chk("ai_first.dmg",      int'(dmg),      6);
    chk("ai_first.accu",     int'(accu),     12);
    // gen0 ACE1 -> E270 drops its output bit to 0.
    chk("step1.gen0_bit", int'(ai_move[0]), 0);

    // Table vectors with generators frozen at reset state.
    drive(1'b0, 1'b1, 1'b0, 2'd0);
    step(); void'(exp_q.pop_front());
    for (int v = 0; v < 6; v++) begin
      drive(1'b1, 1'b1, vecs[v].actr, vecs[v].p_move);
      step(); void'(exp_q.pop_front());
      chk($sformatf("vec%0d.move_sel", v), int'(move_sel), int'(vecs[v].exp_sel));
      chk($sformatf("vec%0d.dmg", v),      int'(dmg),      int'(vecs[v].exp_dmg));
      chk($sformatf("vec%0d.accu", v),     int'(accu),     int'(vecs[v].exp_accu));
      chk($sformatf("vec%0d.ai_move", v),  int'(ai_move),  1);
      chk($sformatf("vec%0d.acc_roll", v), int'(acc_roll), 5);
      chk($sformatf("vec%0d.hit", v),      int'(hit),      1);
    end

    // Run a while, then hold stop for 10 edges, then resume.
    drive(1'b1, 1'b0, 1'b1, 2'd0);
    for (int k = 0; k < 7; k++) begin step(); check_all("pre_stop"); end
    begin
      logic [1:0] h_ai;
      logic [3:0] h_roll;
      h_ai = ai_move; h_roll = acc_roll;
      drive(1'b1, 1'b1, 1'b0, 2'd2);
      for (int k = 0; k < 10; k++) begin step(); check_all("stop"); end
      chk("stop.ai_hold",   int'(ai_move),  int'(h_ai));
      chk("stop.roll_hold", int'(acc_roll), int'(h_roll));
    end
    drive(1'b1, 1'b0, 1'b0, 2'd1);
    for (int k = 0; k < 5; k++) begin step(); check_all("resume"); end

    // Reset mid-operation beats stop and actr.
    drive(1'b0, 1'b1, 1'b1, 2'd3);
    step(); check_all("mid_reset");
    chk("mid_reset.dmg",  int'(dmg),  4);
    chk("mid_reset.accu", int'(accu), 15);

    // Accuracy boundary: walk until the roll is 9..15, freeze, select move 2.
    drive(1'b1, 1'b0, 1'b0, 2'd0);
    begin
      int guard = 0;
      while (m_roll() < 4'd9 && guard < 2000) begin step(); check_all("seek"); guard++; end
      chk("seek.found_high_roll", int'(m_roll() >= 4'd9), 1);
    end
    drive(1'b1, 1'b1, 1'b0, 2'd2);
    step(); check_all("acc_miss");
`ifdef ACCU_CHECK_EN
    chk("acc_miss.hit_const", int'(hit), 0);
`else
    chk("acc_miss.hit_const", int'(hit), 1);
`endif

    // Randomized run.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      step(); check_all("rand");
    end

    // Full period: from reset every generator returns to its seed.
    drive(1'b0, 1'b0, 1'b0, 2'd0);
    step(); check_all("period_reset");
    drive(1'b1, 1'b0, 1'b0, 2'd0);
    for (int k = 0; k < 65535; k++) begin
      step(); void'(exp_q.pop_front());
    end
    chk("period.model_gen0", int'(m_s[0]), int'(seed_tab[0]));
    chk("period.ai_move",  int'(ai_move),  1);
    chk("period.acc_roll", int'(acc_roll), 5);
    step(); check_all("period_next");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
